// File: rtl/warp_divergence_tracker.sv
// Per-warp PC, active mask and SIMT divergence stack, fed by fetch reports and
// branch resolutions. Each warp is an independent lane instance.

module warp_divergence_lane #(
  parameter int WarpWidth  = 4,
  parameter int PcWidth    = 16,
  parameter int StackDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [PcWidth-1:0]   start_pc_i,
  input  logic                 fe_i,
  input  logic [PcWidth-1:0]   fe_next_pc_i,
  input  logic                 fe_is_branch_i,
  input  logic                 fe_is_stop_i,
  input  logic                 br_i,
  input  logic [WarpWidth-1:0] br_mask_i,
  input  logic [PcWidth-1:0]   br_pc_i,
  output logic                 ready_o,
  output logic [PcWidth-1:0]   pc_o,
  output logic [WarpWidth-1:0] mask_o,
  output logic                 done_o,
  output logic                 ovf_o
);
  localparam int SpWidth  = $clog2(StackDepth + 1);
  localparam int IdxWidth = StackDepth > 1 ? $clog2(StackDepth) : 1;

  typedef enum logic [1:0] {IDLE, RUN, WAIT_BR, DONE} state_e;
  typedef struct packed {
    logic [PcWidth-1:0]   pc;
    logic [WarpWidth-1:0] mask;
  } stk_ent_t;

  state_e               state_q;
  logic [PcWidth-1:0]   pc_q;
  logic [WarpWidth-1:0] mask_q;
  logic [SpWidth-1:0]   sp_q;
  logic                 ovf_q;
  stk_ent_t             stk_q [StackDepth];

  logic [WarpWidth-1:0] taken, not_taken;
  logic [IdxWidth-1:0]  push_idx, top_idx;
  logic                 stk_full;

  always_comb begin
    taken     = br_mask_i & mask_q;
    not_taken = mask_q & ~taken;
    push_idx  = IdxWidth'(sp_q);
    top_idx   = IdxWidth'(sp_q - 1'b1);
    stk_full  = (sp_q == SpWidth'(StackDepth));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < StackDepth; i++) stk_q[i] <= '0;
    end else if (start_i) begin
      state_q <= RUN;
      pc_q    <= start_pc_i;
      mask_q  <= '1;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
    end else if (fe_i && state_q == RUN) begin
      pc_q <= fe_next_pc_i;
      if (fe_is_branch_i) begin
        state_q <= WAIT_BR;
      end else if (fe_is_stop_i) begin
        if (sp_q != '0) begin
          pc_q   <= stk_q[top_idx].pc;
          mask_q <= stk_q[top_idx].mask;
          sp_q   <= sp_q - 1'b1;
        end else begin
          state_q <= DONE;
          mask_q  <= '0;
        end
      end
    end else if (br_i && state_q == WAIT_BR) begin
      state_q <= RUN;
      if (taken != '0 && not_taken == '0) begin
        pc_q <= br_pc_i;
      end else if (taken != '0) begin
        // Divergent: not-taken threads resume at the stored fall-through pc.
        if (!stk_full) begin
          stk_q[push_idx] <= '{pc: pc_q, mask: not_taken};
          sp_q            <= sp_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
        pc_q   <= br_pc_i;
        mask_q <= taken;
      end
    end
  end

  assign ready_o = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign pc_o    = pc_q;
  assign mask_o  = mask_q;
  assign ovf_o   = ovf_q;

  ap_fe_in_run: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fe_i && !start_i) |-> state_q == RUN)
    else $warning("fetch ignored: warp not in RUN");
  ap_br_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (br_i && !start_i) |-> state_q == WAIT_BR)
    else $warning("branch resolution ignored: warp not in WAIT_BR");
endmodule

module warp_divergence_tracker #(
  parameter int NumWarps   = 8,
  parameter int WarpWidth  = 4,
  parameter int PcWidth    = 16,
  parameter int StackDepth = 4,
  parameter int WidWidth   = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_valid_i,
  input  logic [WidWidth-1:0]                start_wid_i,
  input  logic [PcWidth-1:0]                 start_pc_i,
  input  logic                               fe_valid_i,
  input  logic [WidWidth-1:0]                fe_wid_i,
  input  logic [PcWidth-1:0]                 fe_next_pc_i,
  input  logic                               fe_is_branch_i,
  input  logic                               fe_is_stop_i,
  input  logic                               bru_branch_i,
  input  logic [WidWidth-1:0]                bru_branch_wid_i,
  input  logic [WarpWidth-1:0]               bru_branching_mask_i,
  input  logic [PcWidth-1:0]                 bru_branch_pc_i,
  output logic [NumWarps-1:0]                warp_ready_o,
  output logic [NumWarps-1:0][PcWidth-1:0]   warp_pc_o,
  output logic [NumWarps-1:0][WarpWidth-1:0] warp_act_mask_o,
  output logic [NumWarps-1:0]                warp_done_o,
  output logic [NumWarps-1:0]                stack_overflow_o
);
  typedef logic [PcWidth-1:0]   pc_t;
  typedef logic [WarpWidth-1:0] act_mask_t;
  typedef logic [WidWidth-1:0]  wid_t;

  for (genvar w = 0; w < NumWarps; w++) begin : g_warp
    warp_divergence_lane #(
      .WarpWidth (WarpWidth),
      .PcWidth   (PcWidth),
      .StackDepth(StackDepth)
    ) u_lane (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_valid_i && start_wid_i == wid_t'(w)),
      .start_pc_i    (pc_t'(start_pc_i)),
      .fe_i          (fe_valid_i && fe_wid_i == wid_t'(w)),
      .fe_next_pc_i  (fe_next_pc_i),
      .fe_is_branch_i(fe_is_branch_i),
      .fe_is_stop_i  (fe_is_stop_i),
      .br_i          (bru_branch_i && bru_branch_wid_i == wid_t'(w)),
      .br_mask_i     (act_mask_t'(bru_branching_mask_i)),
      .br_pc_i       (bru_branch_pc_i),
      .ready_o       (warp_ready_o[w]),
      .pc_o          (warp_pc_o[w]),
      .mask_o        (warp_act_mask_o[w]),
      .done_o        (warp_done_o[w]),
      .ovf_o         (stack_overflow_o[w])
    );
  end
endmodule

// File: tb/tb_warp_divergence_tracker.sv
// Self-checking bench: a vector table plus hand sequences, expectations queued
// when stimulus is driven and compared after the clock edge.
module tb_warp_divergence_tracker;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic sv, fv, fbr, fstop, bv;
  logic [2:0] swid, fwid, bwid;
  logic [15:0] spc, fpc, bpc;
  logic [3:0] bmask;

  logic [7:0] rdy0, done0, ovf0, rdy1, done1, ovf1;
  logic [7:0][15:0] pc0, pc1;
  logic [7:0][3:0] msk0, msk1;

  always #5 clk = ~clk;

  warp_divergence_tracker dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .start_valid_i(sv), .start_wid_i(swid), .start_pc_i(spc),
    .fe_valid_i(fv), .fe_wid_i(fwid), .fe_next_pc_i(fpc),
    .fe_is_branch_i(fbr), .fe_is_stop_i(fstop),
    .bru_branch_i(bv), .bru_branch_wid_i(bwid),
    .bru_branching_mask_i(bmask), .bru_branch_pc_i(bpc),
    .warp_ready_o(rdy0), .warp_pc_o(pc0), .warp_act_mask_o(msk0),
    .warp_done_o(done0), .stack_overflow_o(ovf0));

  warp_divergence_tracker #(.StackDepth(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .start_valid_i(sv), .start_wid_i(swid), .start_pc_i(spc),
    .fe_valid_i(fv), .fe_wid_i(fwid), .fe_next_pc_i(fpc),
    .fe_is_branch_i(fbr), .fe_is_stop_i(fstop),
    .bru_branch_i(bv), .bru_branch_wid_i(bwid),
    .bru_branching_mask_i(bmask), .bru_branch_pc_i(bpc),
    .warp_ready_o(rdy1), .warp_pc_o(pc1), .warp_act_mask_o(msk1),
    .warp_done_o(done1), .stack_overflow_o(ovf1));

  typedef struct {
    logic sv; logic [2:0] swid; logic [15:0] spc;
    logic fv; logic [2:0] fwid; logic [15:0] fpc; logic fbr, fstop;
    logic bv; logic [2:0] bwid; logic [3:0] bmask; logic [15:0] bpc;
    int cw; logic rdy; logic [15:0] pc; logic [3:0] mask; logic done;
  } vec_t;

  typedef struct {
    string nm; bit d1; int w;
    logic rdy; logic [15:0] pc; logic [3:0] mask; logic done; logic ovf;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0, n_tot = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(int s, int sw, int sp, int f, int fw, int fp, int fb, int fs,
                              int b, int bw, int bm, int bp, int cw, int r, int p, int m, int d);
    vec_t v;
    v.sv = 1'(s); v.swid = 3'(sw); v.spc = 16'(sp);
    v.fv = 1'(f); v.fwid = 3'(fw); v.fpc = 16'(fp); v.fbr = 1'(fb); v.fstop = 1'(fs);
    v.bv = 1'(b); v.bwid = 3'(bw); v.bmask = 4'(bm); v.bpc = 16'(bp);
    v.cw = cw; v.rdy = 1'(r); v.pc = 16'(p); v.mask = 4'(m); v.done = 1'(d);
    return v;
  endfunction

  task automatic idle();
    sv = 0; swid = 0; spc = 0; fv = 0; fwid = 0; fpc = 0; fbr = 0; fstop = 0;
    bv = 0; bwid = 0; bmask = 0; bpc = 0;
  endtask

  task automatic ds(int w, int p);
    sv = 1; swid = 3'(w); spc = 16'(p);
  endtask
  task automatic df(int w, int p, int br, int st);
    fv = 1; fwid = 3'(w); fpc = 16'(p); fbr = 1'(br); fstop = 1'(st);
  endtask
  task automatic db(int w, int m, int p);
    bv = 1; bwid = 3'(w); bmask = 4'(m); bpc = 16'(p);
  endtask

  task automatic ex(string nm, bit d1, int w, int r, int p, int m, int d, int o);
    exp_t e;
    e.nm = nm; e.d1 = d1; e.w = w; e.rdy = 1'(r); e.pc = 16'(p);
    e.mask = 4'(m); e.done = 1'(d); e.ovf = 1'(o);
    sb.push_back(e);
  endtask

  // Clock edge, then compare every queued expectation against the DUT.
  task automatic step();
    exp_t e;
    logic r, d, o; logic [15:0] p; logic [3:0] m;
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.d1) begin r = rdy1[e.w]; p = pc1[e.w]; m = msk1[e.w]; d = done1[e.w]; o = ovf1[e.w]; end
      else      begin r = rdy0[e.w]; p = pc0[e.w]; m = msk0[e.w]; d = done0[e.w]; o = ovf0[e.w]; end
      chk({e.nm, ".ready"}, 128'(r), 128'(e.rdy));
      chk({e.nm, ".pc"},    128'(p), 128'(e.pc));
      chk({e.nm, ".mask"},  128'(m), 128'(e.mask));
      chk({e.nm, ".done"},  128'(d), 128'(e.done));
      chk({e.nm, ".ovf"},   128'(o), 128'(e.ovf));
    end
    idle();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, ".ready"}, 128'(rdy0), '0);
    chk({nm, ".pc"},    128'(pc0),  '0);
    chk({nm, ".mask"},  128'(msk0), '0);
    chk({nm, ".done"},  128'(done0), '0);
    chk({nm, ".ovf"},   128'(ovf0), '0);
    chk({nm, ".d1_pc"}, 128'(pc1),  '0);
  endtask

  vec_t tbl[16];

  initial begin
    //        start       fetch               resolve          check w: rdy pc mask done
    tbl[0]  = mk(1,2,'h10, 0,0,0,0,0,     0,0,0,0,       2, 1,'h10,'hF,0);
    tbl[1]  = mk(0,0,0,    1,2,'h11,0,0,  0,0,0,0,       2, 1,'h11,'hF,0);
    tbl[2]  = mk(1,1,'h20, 0,0,0,0,0,     0,0,0,0,       1, 1,'h20,'hF,0);
    tbl[3]  = mk(0,0,0,    1,1,'h21,1,0,  0,0,0,0,       1, 0,'h21,'hF,0);
    tbl[4]  = mk(0,0,0,    0,0,0,0,0,     0,0,0,0,       1, 0,'h21,'hF,0);
    tbl[5]  = mk(0,0,0,    0,0,0,0,0,     1,1,'hF,'h40,  1, 1,'h40,'hF,0);
    tbl[6]  = mk(0,0,0,    1,1,'h41,1,0,  0,0,0,0,       1, 0,'h41,'hF,0);
    tbl[7]  = mk(0,0,0,    0,0,0,0,0,     1,1,'h0,'h50,  1, 1,'h41,'hF,0);
    tbl[8]  = mk(1,0,0,    0,0,0,0,0,     0,0,0,0,       0, 1,'h00,'hF,0);
    tbl[9]  = mk(0,0,0,    1,0,'h05,1,0,  0,0,0,0,       0, 0,'h05,'hF,0);
    tbl[10] = mk(0,0,0,    0,0,0,0,0,     1,0,'h3,'h30,  0, 1,'h30,'h3,0);
    tbl[11] = mk(0,0,0,    1,0,'h31,0,1,  0,0,0,0,       0, 1,'h05,'hC,0);
    tbl[12] = mk(0,0,0,    1,0,'h06,0,1,  0,0,0,0,       0, 0,'h06,'h0,1);
    tbl[13] = mk(1,5,'h50, 0,0,0,0,0,     0,0,0,0,       5, 1,'h50,'hF,0);
    tbl[14] = mk(1,6,'h60, 0,0,0,0,0,     0,0,0,0,       6, 1,'h60,'hF,0);
    tbl[15] = mk(0,0,0,    1,6,'h61,1,0,  0,0,0,0,       6, 0,'h61,'hF,0);

    idle();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_ni = 1'b1;

    foreach (tbl[i]) begin
      sv = tbl[i].sv; swid = tbl[i].swid; spc = tbl[i].spc;
      fv = tbl[i].fv; fwid = tbl[i].fwid; fpc = tbl[i].fpc; fbr = tbl[i].fbr; fstop = tbl[i].fstop;
      bv = tbl[i].bv; bwid = tbl[i].bwid; bmask = tbl[i].bmask; bpc = tbl[i].bpc;
      ex($sformatf("vec%0d", i), 0, tbl[i].cw, tbl[i].rdy, tbl[i].pc, tbl[i].mask, tbl[i].done, 0);
      step();
    end

    // Three warps updated in the same cycle; w6 diverges (taken 0x5 of 0xF).
    ds(4, 'h44); df(5, 'h51, 0, 0); db(6, 'h5, 'h70);
    ex("conc_w4", 0, 4, 1, 'h44, 'hF, 0, 0);
    ex("conc_w5", 0, 5, 1, 'h51, 'hF, 0, 0);
    ex("conc_w6", 0, 6, 1, 'h70, 'h5, 0, 0);
    step();
    df(6, 'h71, 1, 0); ex("w6_wait", 0, 6, 0, 'h71, 'h5, 0, 0); step();
    ds(6, 'h80);       ex("w6_restart", 0, 6, 1, 'h80, 'hF, 0, 0); step();
    db(6, 'h1, 'h99);  ex("w6_stale", 0, 6, 1, 'h80, 'hF, 0, 0); step();
    df(6, 'h81, 0, 1); ex("w6_stop", 0, 6, 0, 'h81, 'h0, 1, 0); step();

    // Nested divergence on w3: depth-1 instance overflows, depth-4 does not.
    ds(3, 0); step();
    df(3, 'h01, 1, 0); step();
    db(3, 'h3, 'h10); ex("ovf_a1", 1, 3, 1, 'h10, 'h3, 0, 0); step();
    df(3, 'h11, 1, 0); step();
    db(3, 'h1, 'h20);
    ex("ovf_b1", 1, 3, 1, 'h20, 'h1, 0, 1);
    ex("ovf_b0", 0, 3, 1, 'h20, 'h1, 0, 0);
    step();
    df(3, 'h21, 0, 1);
    ex("pop_1", 1, 3, 1, 'h01, 'hC, 0, 1);
    ex("pop_0", 0, 3, 1, 'h11, 'h2, 0, 0);
    step();
    df(3, 'h02, 0, 1);
    ex("end_1", 1, 3, 0, 'h02, 'h0, 1, 1);
    ex("end_0", 0, 3, 1, 'h01, 'hC, 0, 0);
    step();

    // Two stack entries on w0, then reset asserted between edges.
    ds(0, 0); step();
    df(0, 'h01, 1, 0); step();
    db(0, 'h3, 'h10); step();
    df(0, 'h11, 1, 0); step();
    db(0, 'h1, 'h20); ex("pre_rst", 0, 0, 1, 'h20, 'h1, 0, 0); step();
    #2 rst_ni = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk) rst_ni = 1'b1;
    ds(0, 'h30);       ex("post_start", 0, 0, 1, 'h30, 'hF, 0, 0); step();
    df(0, 'h31, 0, 1); ex("post_stop", 0, 0, 0, 'h31, 'h0, 1, 0); step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/warp_divergence_tracker.md
# warp_divergence_tracker

Fetcher-side consumer of the branch unit's resolution interface (`bru_branch_*`). It holds, per warp, the current PC, active thread mask, a fetch-eligibility state and a SIMT divergence stack. The fetcher reports fetched instructions to it, and it stalls a warp on a branch until the branch unit resolves it. It sits between the branch unit and the fetcher/warp scheduler inside the compute unit.

## Interface
Parameters:
- `NumWarps`, 8, warps per compute unit
- `WarpWidth`, 4, threads per warp
- `PcWidth`, 16, program counter width
- `StackDepth`, 4, divergence stack entries per warp (≥1)
- `WidWidth`, derived: `NumWarps > 1 ? $clog2(NumWarps) : 1`; do not override
- Types `pc_t`, `act_mask_t` and `wid_t` are sized from the above.

Ports:
- `clk_i` in 1: the single clock
- `rst_ni` in 1: asynchronous, active-low reset
- `start_valid_i` in 1: launch warp `start_wid_i` at `start_pc_i` with an all-ones mask
- `start_wid_i` in WidWidth; `start_pc_i` in PcWidth
- `fe_valid_i` in 1: the fetcher fetched one instruction for warp `fe_wid_i`
- `fe_wid_i` in WidWidth
- `fe_next_pc_i` in PcWidth: fall-through PC of the fetched instruction
- `fe_is_branch_i` in 1: the fetched instruction is BNZ/BEZ
- `fe_is_stop_i` in 1: the fetched instruction ends the current thread group
- `bru_branch_i` in 1: branch resolved (registered pulse from the branch unit)
- `bru_branch_wid_i` in WidWidth
- `bru_branching_mask_i` in WarpWidth: threads that take the branch
- `bru_branch_pc_i` in PcWidth: branch target
- `warp_ready_o` out NumWarps: warp may be fetched
- `warp_pc_o` out NumWarps×PcWidth: next PC to fetch, per warp
- `warp_act_mask_o` out NumWarps×WarpWidth: active mask, per warp
- `warp_done_o` out NumWarps: warp finished
- `stack_overflow_o` out NumWarps: sticky; the warp lost threads because its stack was full

## Operation
- Each warp has a state: IDLE, RUN, WAIT_BR or DONE. `warp_ready_o[w] = (state == RUN)`; `warp_done_o[w] = (state == DONE)`.
- **Start** (from any state): set pc to `start_pc_i`, mask to all ones, stack pointer to 0, clear overflow, go to RUN.
- **Fetch in RUN:** pc ← `fe_next_pc_i`.
  - If `fe_is_branch_i`: go to WAIT_BR.
  - Else if `fe_is_stop_i` and the stack is non-empty: pop, pc ← entry pc, mask ← entry mask, stay in RUN.
  - Else if `fe_is_stop_i` and the stack is empty: go to DONE, mask ← 0.
  - `fe_is_branch_i` and `fe_is_stop_i` both set is illegal; branch wins.
- **Resolution in WAIT_BR:** let T = `bru_branching_mask_i` & mask and N = mask & ~T.
  - If T == 0: keep pc (fall-through) and mask.
  - If N == 0: pc ← target.
  - Otherwise (divergent): push {stored fall-through pc, N}, then pc ← target, mask ← T.
  - Divergent with the stack full: no push, pc ← target, mask ← T, set `stack_overflow_o[w]`; threads N are dropped.
  - All three cases return to RUN.
- **Ignored events** (each flagged by a non-synthesis assertion):
  - fetch for a warp that is not in RUN
  - `bru_branch_i` for a warp that is not in WAIT_BR
- Stack is LIFO. The pointer range is 0..StackDepth, width `$clog2(StackDepth+1)`.

## Timing
- All state is registered. An event sampled at edge k is visible on the outputs after edge k, with no combinational input→output paths.
- Branch loop: fetch branch at edge k; warp not ready from k. The branch unit's resolution can arrive at edge k+3 at the earliest; the warp is ready again after that edge.
- Reset values for every warp: state IDLE, pc 0, mask 0, stack pointer 0, overflow 0. All outputs are 0.
- Reset asserted mid-operation discards all stacks and pending branches immediately.
- Simultaneous events on different warps (start, fetch, resolution on three different wids) are all applied in the same cycle.
- Same-warp conflicts: start beats fetch and resolution; fetch and resolution cannot coincide legally (RUN vs WAIT_BR).
- Throughput: one fetch, one resolution and one start per cycle.

## Test plan
- **Reset, start, straight-line fetch:** after reset all outputs are 0. Start w2 at PC 0x10 -> next cycle `warp_ready_o[2]=1`, pc 0x10, mask 0xF. Fetch w2 with next_pc 0x11 -> pc 0x11.
- **Uniform branch:** fetch branch w1 (next 0x21) -> ready 0 on w1. Resolve mask 0xF, target 0x40 -> pc 0x40, mask 0xF, ready 1. Repeat with mask 0x0 -> pc 0x21, mask unchanged.
- **Divergence and reconverge:** w0 mask 0xF, branch next 0x05, resolve mask 0x3, target 0x30 -> pc 0x30, mask 0x3. Stop -> pc 0x05, mask 0xC. Stop again -> done 1, ready 0, mask 0.
- **Stack overflow:** StackDepth=1, two nested divergent branches on w3 -> second one sets `stack_overflow_o[3]`. Stop then pops only the first entry.
- **Concurrency:** same cycle: start w4, fetch w5, resolve w6 -> all three updates visible next cycle. Start w6 while w6 is in WAIT_BR -> w6 restarts, and a later stale resolution for w6 is ignored.
- **Asynchronous reset:** assert `rst_ni` low between edges while w0 has two stack entries -> all outputs 0 immediately. After release, a fresh start shows stack pointer 0: a stop goes directly to DONE.
